// File: rtl/picorv32_wbuf_pkg.sv
// Shared types and helpers for the register-file write-back buffer.
package picorv32_wbuf_pkg;

  localparam int WBUF_AW = 6;
  localparam int WBUF_DW = 32;

  localparam logic [WBUF_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WBUF_AW-1:0] addr;
    logic [WBUF_DW-1:0] data;
  } wbuf_entry_t;

  // x0 lives in bank 0 (addr[5]=0) at index 0; Q-bank index 0 is a real register.
  function automatic logic is_zero_reg(input logic [WBUF_AW-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/picorv32_wbuf_fwd.sv
// Youngest-match forwarding search for one read port of the write-back buffer.
module picorv32_wbuf_fwd
  import picorv32_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  wbuf_entry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]     valid,
  input  logic [PW-1:0]        head,
  input  logic [WBUF_AW-1:0]   raddr,
  input  logic [WBUF_DW-1:0]   rf_rdata,
  output logic [WBUF_DW-1:0]   rdata
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from the head so the last match wins.
  always_comb begin
    rdata = rf_rdata;
    idx   = '0;
    if (!is_zero_reg(raddr)) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if (valid[idx] && (entries[idx].addr == raddr)) begin
          rdata = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/picorv32_regs_wbuf.sv
// Write-back buffer in front of the register-file write port, with read forwarding.
// Optional in-place coalescing of same-address writes: define PICORV32_WBUF_COALESCE_EN.
module picorv32_regs_wbuf
  import picorv32_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBUF_AW,
  parameter int DW    = WBUF_DW
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DW-1:0]              wb_data,
  input  logic                       drain_hold,
  input  logic                       flush,
  output logic                       rf_wen,
  output logic [AW-1:0]              rf_waddr,
  output logic [DW-1:0]              rf_wdata,
  input  logic [AW-1:0]              raddr1,
  input  logic [AW-1:0]              raddr2,
  input  logic [DW-1:0]              rf_rdata1,
  input  logic [DW-1:0]              rf_rdata2,
  output logic [DW-1:0]              rdata1,
  output logic [DW-1:0]              rdata2,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  wbuf_entry_t      entries_q [DEPTH];
  wbuf_entry_t      entries_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, young_idx;
  logic [PW:0]      count_q, count_d;
  logic             full, empty, accept, pop, push, coalesce_hit;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign wb_ready  = !full;
  assign accept    = wb_valid && !full;
  assign rf_wen    = !empty && !drain_hold && !flush;
  assign pop       = rf_wen;
  assign young_idx = tail_q - PTR_ONE;

`ifdef PICORV32_WBUF_COALESCE_EN
  // The head leaving this cycle cannot absorb a new write, so that case allocates.
  assign coalesce_hit = accept && !is_zero_reg(wb_addr) && !empty &&
                        (entries_q[young_idx].addr == wb_addr) &&
                        !(pop && (young_idx == head_q));
`else
  assign coalesce_hit = 1'b0;
`endif

  assign push     = accept && !is_zero_reg(wb_addr) && !coalesce_hit;
  assign rf_waddr = entries_q[head_q].addr;
  assign rf_wdata = entries_q[head_q].data;
  assign pending  = count_q;

  // Flush overrides every other queue update in the same cycle.
  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_ONE;
      end
      if (push) begin
        entries_d[tail_q].addr = wb_addr;
        entries_d[tail_q].data = wb_data;
        valid_d[tail_q]        = 1'b1;
        tail_d                 = tail_q + PTR_ONE;
      end
      if (coalesce_hit) begin
        entries_d[young_idx].data = wb_data;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; the valid mask and count gate all use of it.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  picorv32_wbuf_fwd #(.DEPTH(DEPTH), .PW(PW)) u_fwd1 (
    .entries  (entries_q),
    .valid    (valid_q),
    .head     (head_q),
    .raddr    (raddr1),
    .rf_rdata (rf_rdata1),
    .rdata    (rdata1)
  );

  picorv32_wbuf_fwd #(.DEPTH(DEPTH), .PW(PW)) u_fwd2 (
    .entries  (entries_q),
    .valid    (valid_q),
    .head     (head_q),
    .raddr    (raddr2),
    .rf_rdata (rf_rdata2),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_picorv32_regs_wbuf.sv
// Scoreboard bench for picorv32_regs_wbuf: queue-based reference model, directed and random traffic.
module tb_picorv32_regs_wbuf;

  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } m_entry_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid, wb_ready;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drain_hold, flush;
  logic        rf_wen;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  raddr1, raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, rdata1, rdata2;
  logic [2:0]  pending;

  m_entry_t model_q[$];
  m_entry_t sb_q[$];
  int       errors = 0;
  int       checks = 0;

  always #5 clk = ~clk;

  picorv32_regs_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .drain_hold(drain_hold), .flush(flush),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rdata1(rdata1), .rdata2(rdata2), .pending(pending)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] addr, input logic [31:0] raw);
    logic [31:0] r = raw;
    if (addr != 6'd0) begin
      foreach (model_q[i]) if (model_q[i].addr == addr) r = model_q[i].data;
    end
    return r;
  endfunction

  function automatic logic [5:0] rand_addr();
    logic [5:0] a = 6'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a[5] = 1'b1;
    return a;
  endfunction

  // One clock of stimulus; the model state then represents the following edge.
  task automatic apply_stimulus(input logic v, input logic [5:0] a, input logic [31:0] d,
                                input logic hold, input logic fl,
                                input logic [5:0] ra1, input logic [5:0] ra2);
    int          size;
    logic        exp_ready, exp_wen, accepted, coal;
    logic [31:0] exp_r1, exp_r2;
    m_entry_t    e;
    @(posedge clk);
    #1;
    wb_valid = v; wb_addr = a; wb_data = d; drain_hold = hold; flush = fl;
    raddr1 = ra1; raddr2 = ra2; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    size      = model_q.size();
    exp_ready = (size < DEPTH);
    exp_wen   = (size > 0) && !hold && !fl;
    if (exp_wen) sb_q.push_back(model_q[0]);
    exp_r1 = model_read(ra1, rf_rdata1);
    exp_r2 = model_read(ra2, rf_rdata2);
    @(negedge clk);
    check_output("pending", 32'(pending), 32'(size));
    check_output("wb_ready", 32'(wb_ready), 32'(exp_ready));
    check_output("rdata1", rdata1, exp_r1);
    check_output("rdata2", rdata2, exp_r2);
    if (fl) begin
      model_q.delete();
    end else begin
      accepted = v && exp_ready;
      coal     = 1'b0;
`ifdef PICORV32_WBUF_COALESCE_EN
      if (accepted && a != 6'd0 && size > 0 && model_q[size-1].addr == a && !(exp_wen && size == 1))
        coal = 1'b1;
`endif
      if (exp_wen) e = model_q.pop_front();
      if (coal) model_q[model_q.size()-1].data = d;
      else if (accepted && a != 6'd0) begin
        e.addr = a; e.data = d;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n, input logic hold);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 6'd0, 32'd0, hold, 1'b0, rand_addr(), rand_addr());
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    wb_valid = 1'b0;
    #1;
    check_output("rst_pending", 32'(pending), 32'd0);
    check_output("rst_wb_ready", 32'(wb_ready), 32'd1);
    check_output("rst_rf_wen", 32'(rf_wen), 32'd0);
    model_q.delete();
    sb_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: every drained write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check_output("rf_wen", 32'(rf_wen), 32'(sb_q.size() != 0));
      if (rf_wen && sb_q.size() != 0) begin
        check_output("rf_waddr", 32'(rf_waddr), 32'(sb_q[0].addr));
        check_output("rf_wdata", rf_wdata, sb_q[0].data);
      end
      sb_q.delete();
    end
  end

  initial begin
    resetn = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    drain_hold = 1'b0; flush = 1'b0; raddr1 = '0; raddr2 = '0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    #12;
    check_output("init_pending", 32'(pending), 32'd0);
    check_output("init_wb_ready", 32'(wb_ready), 32'd1);
    check_output("init_rf_wen", 32'(rf_wen), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    apply_stimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 6'd5, 6'd0);
    idle(3, 1'b0);

    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 6'(i), 32'(32'h100 + i), 1'b1, 1'b0, 6'(i), 6'd3);
    apply_stimulus(1'b1, 6'd6, 32'h600, 1'b1, 1'b0, 6'd6, 6'd4);
    idle(6, 1'b0);

    apply_stimulus(1'b1, 6'd7, 32'h11, 1'b1, 1'b0, 6'd7, 6'd0);
    apply_stimulus(1'b1, 6'd7, 32'h22, 1'b1, 1'b0, 6'd7, 6'd39);
    apply_stimulus(1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd7, 6'd7);
    idle(4, 1'b0);

    apply_stimulus(1'b1, 6'd0, 32'h1234, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(2, 1'b0);

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 6'(10 + i), $urandom, 1'b1, 1'b0, 6'd11, 6'd9);
    apply_stimulus(1'b1, 6'd9, 32'h9999, 1'b1, 1'b1, 6'd9, 6'd10);
    idle(3, 1'b0);

    apply_stimulus(1'b1, 6'd33, 32'hA1, 1'b1, 1'b0, 6'd33, 6'd1);
    apply_stimulus(1'b1, 6'd2, 32'hA2, 1'b1, 1'b0, 6'd2, 6'd33);
    reset_mid();
    idle(3, 1'b0);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) reset_mid();
      else apply_stimulus($urandom_range(0, 9) < 6, rand_addr(), $urandom,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                          rand_addr(), rand_addr());
    end
    idle(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
